// File: rtl/bus_loader.sv
// Byte-stream driven bus initiator: executes framed load (write) and dump (read)
// commands against a halt-capable memory bus, streaming dumped bytes back out.
module bus_loader #(
  parameter logic [7:0]  CMD_LOAD  = 8'h4C,
  parameter logic [7:0]  CMD_READ  = 8'h52,
  parameter int unsigned READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [23:0] address,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic        bus_enable,
  output logic        write_enable,
  input  logic        bus_halt,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, HDR_A2, HDR_A1, HDR_A0, HDR_L1, HDR_L0,
    W_BYTE, W_BUS, R_BUS, R_SEND, FINISH
  } state_t;

  state_t      state, state_next;
  logic [15:0] count;
  logic [3:0]  wait_cnt;
  logic        is_read;
  logic        rx_fire;
  logic        is_cmd;

  assign rx_ready = (state == IDLE)   || (state == HDR_A2) || (state == HDR_A1) ||
                    (state == HDR_A0) || (state == HDR_L1) || (state == HDR_L0) ||
                    (state == W_BYTE);
  assign busy     = (state != IDLE);
  assign rx_fire  = rx_valid && rx_ready;
  assign is_cmd   = (rx_data == CMD_LOAD) || (rx_data == CMD_READ);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (rx_fire && is_cmd) state_next = HDR_A2;
      HDR_A2: if (rx_fire) state_next = HDR_A1;
      HDR_A1: if (rx_fire) state_next = HDR_A0;
      HDR_A0: if (rx_fire) state_next = HDR_L1;
      HDR_L1: if (rx_fire) state_next = HDR_L0;
      HDR_L0: begin
        if (rx_fire) begin
          if ({count[15:8], rx_data} == 16'd0) state_next = FINISH;
          else if (is_read)                    state_next = R_BUS;
          else                                 state_next = W_BYTE;
        end
      end
      W_BYTE: if (rx_fire) state_next = W_BUS;
      W_BUS:  if (!bus_halt) state_next = (count == 16'd1) ? FINISH : W_BYTE;
      R_BUS:  if (!bus_halt && (wait_cnt == 4'd0)) state_next = R_SEND;
      R_SEND: if (tx_ready) state_next = (count == 16'd1) ? FINISH : R_BUS;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs follow the next state so enables line up with the state they decode
  always_ff @(posedge clk) begin
    if (reset) begin
      address      <= '0;
      data_out     <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      bus_enable   <= 1'b0;
      write_enable <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      count        <= '0;
      wait_cnt     <= '0;
      is_read      <= 1'b0;
    end else begin
      bus_enable   <= (state_next == W_BUS) || (state_next == R_BUS);
      write_enable <= (state_next == W_BUS);
      tx_valid     <= (state_next == R_SEND);
      done         <= (state_next == FINISH);
      error        <= (state == IDLE) && rx_fire && !is_cmd;

      if ((state_next == R_BUS) && (state != R_BUS))
        wait_cnt <= 4'(READ_WAIT);
      else if ((state == R_BUS) && !bus_halt && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;

      case (state)
        IDLE:   if (rx_fire) is_read <= (rx_data == CMD_READ);
        HDR_A2: if (rx_fire) address[23:16] <= rx_data;
        HDR_A1: if (rx_fire) address[15:8]  <= rx_data;
        HDR_A0: if (rx_fire) address[7:0]   <= rx_data;
        HDR_L1: if (rx_fire) count[15:8]    <= rx_data;
        HDR_L0: if (rx_fire) count[7:0]     <= rx_data;
        W_BYTE: if (rx_fire) data_out       <= rx_data;
        W_BUS: begin
          if (!bus_halt) begin
            address <= address + 24'd1;
            count   <= count - 16'd1;
          end
        end
        R_BUS:  if (!bus_halt && (wait_cnt == 4'd0)) tx_data <= data_in;
        R_SEND: begin
          if (tx_ready) begin
            address <= address + 24'd1;
            count   <= count - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_loader.sv
// Randomized bench for bus_loader: a memory-transaction reference model predicts
// bus writes, dumped bytes, done and error pulses from the frame contents.
module tb_bus_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [23:0] address;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        bus_enable;
  logic        write_enable;
  logic        bus_halt;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  bus_loader #(.CMD_LOAD(8'h4C), .CMD_READ(8'h52), .READ_WAIT(1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .address(address),
    .data_out(data_out), .data_in(data_in), .bus_enable(bus_enable),
    .write_enable(write_enable), .bus_halt(bus_halt), .busy(busy), .done(done), .error(error)
  );

  // Read-side memory contents as a function of address
  function automatic logic [7:0] rd_model(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16];
  endfunction
  assign data_in = rd_model(address);

  int n_chk = 0;
  int n_pass = 0;
  int halt_mode = 0;
  int tx_mode = 0;
  int halt_cnt = 0;
  int hold_cnt = 0;
  bit gaps = 1'b0;
  int done_cnt = 0;
  int err_cnt = 0;
  int be_cyc = 0;
  int be101 = 0;
  logic [31:0] wr_obs[$];
  logic [31:0] exp_wr[$];
  logic [7:0]  tx_obs[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  payload[$];
  logic        p_be = 1'b0, p_we = 1'b0, p_halt = 1'b0, p_txv = 1'b0, p_txr = 1'b0;
  logic [23:0] p_addr = '0;
  logic [7:0]  p_dout = '0, p_txd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bus and tx-side stimulus, driven just after each rising edge
  initial begin
    bus_halt = 1'b0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (halt_mode)
        1: bus_halt = ($urandom_range(0, 2) == 0);
        2: begin
          if (bus_enable && write_enable && address == 24'h000101 && halt_cnt < 5) begin
            bus_halt = 1'b1;
            halt_cnt++;
          end else bus_halt = 1'b0;
        end
        default: bus_halt = 1'b0;
      endcase
      case (tx_mode)
        1: tx_ready = ($urandom_range(0, 1) == 1);
        2: begin
          if (tx_valid && hold_cnt < 3) begin
            tx_ready = 1'b0;
            hold_cnt++;
          end else tx_ready = 1'b1;
        end
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Observe completed transfers and frozen-while-stalled behaviour
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (p_be && p_halt)
          check("halt_hold", 64'({bus_enable, write_enable, address, data_out}),
                64'({1'b1, p_we, p_addr, p_dout}));
        if (p_txv && !p_txr)
          check("tx_hold", 64'({tx_valid, tx_data}), 64'({1'b1, p_txd}));
        if (bus_enable && write_enable && !bus_halt) wr_obs.push_back({address, data_out});
        if (tx_valid && tx_ready) tx_obs.push_back(tx_data);
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (bus_enable) be_cyc++;
        if (bus_enable && write_enable && address == 24'h000101) be101++;
      end
      p_be   = bus_enable && !reset;
      p_we   = write_enable;
      p_halt = bus_halt;
      p_addr = address;
      p_dout = data_out;
      p_txv  = tx_valid && !reset;
      p_txr  = tx_ready;
      p_txd  = tx_data;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    rx_valid = 1'b0;
    if (!ok) check("rx_accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic compare_queues();
    check("wr_count", 64'(wr_obs.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_obs.size(); i++)
      check("wr_addr_data", 64'(wr_obs[i]), 64'(exp_wr[i]));
    check("tx_count", 64'(tx_obs.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_obs.size(); i++)
      check("tx_byte", 64'(tx_obs[i]), 64'(exp_tx[i]));
    wr_obs.delete();
    exp_wr.delete();
    tx_obs.delete();
    exp_tx.delete();
  endtask

  // Sends one frame (payload taken from the payload queue for loads) and checks its effects
  task automatic run_frame(input logic [7:0] cmd, input logic [23:0] a, input int len);
    int          d0 = done_cnt;
    logic [15:0] l = 16'(len);
    logic [23:0] ai;
    if (cmd == 8'h52)
      for (int i = 0; i < len; i++) begin
        ai = a + 24'(i);
        exp_tx.push_back(rd_model(ai));
      end
    send_byte(cmd);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(l[15:8]);
    send_byte(l[7:0]);
    if (len == 0) check("len0_done", 64'(done), 64'(1));
    if (cmd == 8'h4C)
      for (int i = 0; i < len; i++) begin
        ai = a + 24'(i);
        exp_wr.push_back({ai, payload[i]});
        send_byte(payload[i]);
        check("wr_launch", 64'({bus_enable, write_enable, address, data_out}),
              64'({1'b1, 1'b1, ai, payload[i]}));
      end
    for (int k = 0; k < 3000 && done_cnt == d0; k++) tick();
    check("done_once", 64'(done_cnt - d0), 64'(1));
    tick();
    check("idle_after", 64'(busy), 64'(0));
    compare_queues();
  endtask

  task automatic bad_byte(input logic [7:0] b);
    int e0 = err_cnt;
    int b0 = be_cyc;
    send_byte(b);
    check("err_pulse", 64'(error), 64'(1));
    check("err_busy", 64'(busy), 64'(0));
    tick();
    check("err_one_cycle", 64'(error), 64'(0));
    check("err_count", 64'(err_cnt - e0), 64'(1));
    check("err_no_bus", 64'(be_cyc - b0), 64'(0));
  endtask

  task automatic check_reset_values();
    check("rst_address", 64'(address), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_tx_valid", 64'(tx_valid), 64'(0));
    check("rst_bus_enable", 64'(bus_enable), 64'(0));
    check("rst_write_enable", 64'(write_enable), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_rx_ready", 64'(rx_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int b0;
    int h0;
    int d0;
    int r;
    int len;
    logic [23:0] a;
    logic [7:0]  bb;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    check_reset_values();
    reset = 1'b0;
    tick();

    // Plain load, no halt: one-cycle writes
    payload = '{8'hAA, 8'hBB, 8'hCC};
    b0 = be_cyc;
    run_frame(8'h4C, 24'h000100, 3);
    check("load_be_cycles", 64'(be_cyc - b0), 64'(3));

    // Same load with a 5-cycle halt on the second write
    halt_mode = 2;
    halt_cnt  = 0;
    h0 = be101;
    run_frame(8'h4C, 24'h000100, 3);
    check("halt_write_cycles", 64'(be101 - h0), 64'(6));
    halt_mode = 0;

    // Dump across the 24-bit wrap with tx back-pressure on the first byte
    tx_mode  = 2;
    hold_cnt = 0;
    run_frame(8'h52, 24'hFFFFFE, 3);
    check("read_wrap_addr", 64'(address), 64'(24'h000001));
    tx_mode = 0;

    // Unknown command then a normal frame
    bad_byte(8'h13);
    payload = '{8'h5A};
    run_frame(8'h4C, 24'h001000, 1);

    // Zero-length header, next byte is a command again
    b0 = be_cyc;
    run_frame(8'h4C, 24'h001000, 0);
    check("len0_no_bus", 64'(be_cyc - b0), 64'(0));
    payload = '{8'h01, 8'h02};
    run_frame(8'h4C, 24'h002000, 2);

    // Reset after the first of three payload bytes has been written
    d0 = done_cnt;
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    exp_wr.push_back({24'h000040, 8'h11});
    tick();
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    repeat (4) tick();
    check("rst_no_done", 64'(done_cnt - d0), 64'(0));
    compare_queues();
    payload = '{8'h21, 8'h22, 8'h23};
    run_frame(8'h4C, 24'h000040, 3);

    // Randomized frames with halts, back-pressure and rx gaps
    halt_mode = 1;
    tx_mode   = 1;
    gaps      = 1'b1;
    for (int f = 0; f < 30; f++) begin
      r   = $urandom_range(0, 4);
      len = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 3));
      else a = 24'($urandom);
      if (r == 0) begin
        bb = 8'($urandom);
        if (bb == 8'h4C || bb == 8'h52) bb = 8'h00;
        bad_byte(bb);
      end else if (r <= 2) begin
        payload.delete();
        for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
        run_frame(8'h4C, a, len);
      end else begin
        run_frame(8'h52, a, len);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_loader.md
# bus_loader

Byte-stream-driven bus initiator that sits on the CPU side of `memory_bus` and drives its address/data/enable inputs while honouring `bus_halt`. It executes framed load and dump commands from an upstream byte source, normally the UART receiver. Loads write payload bytes to consecutive bus addresses; dumps read consecutive addresses and stream the bytes out. While `busy` is high, top level muxes the bus away from the CPU.

## Interface
Parameters:
- `CMD_LOAD`, 8'h4C, command byte for a write (load) frame
- `CMD_READ`, 8'h52, command byte for a read (dump) frame
- `READ_WAIT`, 1, extra cycles address is held before `data_in` is captured on reads (0–15)

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `rx_data`  in  8  incoming command/payload byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  block accepts a byte this cycle
- `tx_data`  out  8  dumped byte
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  downstream accepts `tx_data`
- `address`  out  24  bus address
- `data_out`  out  8  write data to bus
- `data_in`  in  8  read data from bus
- `bus_enable`  out  1  bus access active
- `write_enable`  out  1  access is a write
- `bus_halt`  in  1  bus not ready; hold the access
- `busy`  out  1  frame in progress (state != IDLE)
- `done`  out  1  one-cycle pulse when a frame completes
- `error`  out  1  one-cycle pulse on an unknown command byte

## Operation
- Frame format: cmd, addr[23:16], addr[15:8], addr[7:0], len[15:8], len[7:0], then `len` payload bytes (load only). Header fields are big-endian.
- A byte transfers on any rising edge with `rx_valid && rx_ready`.
- `rx_ready` is high only in IDLE, HDR_A2, HDR_A1, HDR_A0, HDR_L1, HDR_L0 and W_BYTE.
- States: IDLE → HDR_A2 → HDR_A1 → HDR_A0 → HDR_L1 → HDR_L0 → (load) W_BYTE ⇄ W_BUS / (read) R_BUS → R_SEND → R_BUS … → FINISH → IDLE.
- In IDLE, a byte other than `CMD_LOAD`/`CMD_READ` pulses `error`, is consumed, and the state stays IDLE.
- `len` = 0 goes from HDR_L0 directly to FINISH with no bus access.
- W_BYTE: accept a payload byte into `data_out`, then go to W_BUS.
- W_BUS: `bus_enable` = 1, `write_enable` = 1; `address` and `data_out` are held stable.
  - Leave W_BUS on the first cycle with `bus_halt` = 0.
  - On leaving: increment `address`, decrement the remaining count, then go to W_BYTE, or to FINISH if the count reaches 0.
- R_BUS: `bus_enable` = 1, `write_enable` = 0. A wait counter loads `READ_WAIT` on entry and decrements each cycle `bus_halt` = 0.
  - On the first cycle with `bus_halt` = 0 and counter = 0, capture `data_in` into `tx_data` and go to R_SEND.
- R_SEND: `tx_valid` = 1, `bus_enable` = 0. On `tx_ready`: increment `address`, decrement count, then go to R_BUS or FINISH.
- FINISH: pulse `done`, go to IDLE.
- Address arithmetic is 24-bit modulo: 24'hFFFFFF + 1 = 24'h000000. The remaining count is 16 bits; a frame never exceeds 65535 bytes.
- `bus_enable` is high only in W_BUS and R_BUS; `write_enable` is high only in W_BUS.

## Timing
- All outputs are registered, except `busy` and `rx_ready`, which decode the state register.
- Reset values: `address` = 0, `data_out` = 0, `tx_data` = 0, `tx_valid` = 0, `bus_enable` = 0, `write_enable` = 0, `done` = 0, `error` = 0, `rx_ready` = 1 (IDLE), `busy` = 0.
- Reset mid-frame abandons the frame immediately: no further bus access, no `done`, partial data remains in memory.
- Load: a payload byte accepted at edge N gives `bus_enable`/`write_enable` high during cycle N+1. With no halt, that is 2 cycles per byte.
- Read: R_BUS lasts READ_WAIT+1 cycles plus the number of `bus_halt` cycles; `tx_valid` rises the cycle after capture.
- `bus_halt` asserted in any cycle of W_BUS/R_BUS freezes `address`, `data_out` and the enables. A halt cycle does not decrement the wait counter.
- `rx_valid` during W_BUS/R_BUS/R_SEND/FINISH is ignored (`rx_ready` = 0); the byte must be held by the source.
- `done` rises exactly one cycle after the final bus write completes, or after the final `tx_ready` handshake.

## Test plan
- Load 4C 00 01 00 00 03 AA BB CC, no halt: three write cycles at 0x000100/101/102 with data AA/BB/CC, each 1 cycle wide; then `done` pulse, `busy` = 0.
- Same load with `bus_halt` high for 5 cycles on the second write: `address` = 0x000101 and `data_out` = BB held through the halt; the write completes on the 6th cycle; total of 3 writes.
- Read 52 FF FF FE 00 03 with `READ_WAIT` = 1 and bus model returning low address byte: `tx_data` sequence FE, FF, 00. Address wraps to 0x000000. `tx_ready` held low for 3 cycles keeps `tx_valid` = 1 and `tx_data` stable.
- Byte 0x13 in IDLE: `error` pulses once, `bus_enable` stays 0, `busy` stays 0; a following valid frame executes normally.
- Load header with `len` = 0000: no `bus_enable`, `done` pulses after HDR_L0, and the next byte is treated as a command.
- `reset` asserted after the first of 3 payload bytes: next cycle all outputs are at reset values, no `done`; a fresh frame then completes correctly.
